// File: rtl/spi_flash_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI flash responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_PD    = 8'hB9;
  localparam logic [7:0] OP_RPD   = 8'hAB;
  localparam logic [7:0] OP_RST   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Synchronizes the SPI pins into clk and produces SCK rise/fall and CSB fall/rise strobes.
// Latency: a pin edge shows up as a one-cycle strobe SYNC_STAGES cycles after the edge.
// Backpressure: none; strobes are single-cycle pulses that must be consumed immediately.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flash_csb,
  input  logic flash_clk,
  input  logic flash_io0_di,
  output logic csb_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_fall,
  output logic csb_rise
);

  logic [SYNC_STAGES-1:0] csb_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_d;
  logic                   csb_d;

  // Synchronizer chains plus one history flop per edge-detected signal; csb idles deselected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_q  <= '1;
      sck_q  <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      csb_d  <= 1'b1;
    end else begin
      csb_q  <= {csb_q[SYNC_STAGES-2:0], flash_csb};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], flash_clk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], flash_io0_di};
      sck_d  <= sck_q[SYNC_STAGES-1];
      csb_d  <= csb_q[SYNC_STAGES-1];
    end
  end

  assign csb_s    = csb_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise =  sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] &  sck_d;
  assign csb_fall = ~csb_q[SYNC_STAGES-1] &  csb_d;
  assign csb_rise =  csb_q[SYNC_STAGES-1] & ~csb_d;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash emulator: decodes read/fast-read/power commands and streams bytes from a byte memory.
// Latency: SPI edges act SYNC_STAGES+1 clk after the pin; one mem request per byte, prefetched one byte ahead.
// Backpressure: mem_valid holds until mem_ready; a byte not prefetched by its boundary goes out as 0xFF.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic              flash_io0_di,
  output logic              flash_io1_do,
  output logic              flash_io1_oe,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              powered_down,
  output logic              underrun
);

  logic csb_s, mosi_s, sck_rise, sck_fall, csb_fall, csb_rise;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .reset        (reset),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_di (flash_io0_di),
    .csb_s        (csb_s),
    .mosi_s       (mosi_s),
    .sck_rise     (sck_rise),
    .sck_fall     (sck_fall),
    .csb_fall     (csb_fall),
    .csb_rise     (csb_rise)
  );

  state_t            state, state_nxt;
  logic [7:0]        bit_cnt;
  logic [22:0]       sh_in;
  logic [23:0]       addr_full;
  logic [7:0]        op_byte;
  logic              fast;
  logic [ADDR_W-1:0] nxt_addr;   // address of the byte the prefetch buffer is meant to hold
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        sh_out;
  logic [7:0]        byte_out;
  logic              buf_vld;
  logic [7:0]        buf_dat;
  logic              req_want;   // a request is owed but the port is still busy
  logic              start, shift_en, cmd_done, addr_done, dummy_done, data_fall, byte_edge;
  logic              new_req, buf_load;

  assign addr_full = {sh_in, mosi_s};
  assign op_byte   = addr_full[7:0];
  assign new_req   = addr_done | byte_edge;
  assign req_addr  = addr_done ? addr_full[ADDR_W-1:0] : nxt_addr + ADDR_W'(1);
  assign byte_out  = buf_vld ? buf_dat : 8'hFF;
  // Only a response for the byte currently wanted is kept; stale or aborted responses are dropped.
  assign buf_load  = mem_valid && mem_ready && !csb_s && !byte_edge &&
                     (state == DUMMY || state == DATA) && (mem_addr == nxt_addr);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle event decode; deselect overrides every SPI edge.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    cmd_done   = 1'b0;
    addr_done  = 1'b0;
    dummy_done = 1'b0;
    data_fall  = 1'b0;
    byte_edge  = 1'b0;
    if (csb_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (csb_fall) begin
          start     = 1'b1;
          state_nxt = CMD;
        end
        CMD: if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 8'd7) begin
            cmd_done = 1'b1;
            if (powered_down) state_nxt = IGNORE;
            else begin
              case (op_byte)
                OP_READ, OP_FREAD:     state_nxt = ADDR;
                OP_PD, OP_RPD, OP_RST: state_nxt = IGNORE;
                default:               state_nxt = IGNORE;
              endcase
            end
          end
        end
        ADDR: if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 8'd23) begin
            addr_done = 1'b1;
            state_nxt = fast ? DUMMY : DATA;
          end
        end
        DUMMY: if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 8'(DUMMY_CYCLES - 1)) begin
            dummy_done = 1'b1;
            state_nxt  = DATA;
          end
        end
        DATA: if (sck_fall) begin
          data_fall = 1'b1;
          byte_edge = (bit_cnt[2:0] == 3'd0);
        end
        IGNORE:  state_nxt = IGNORE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift/count datapath, MISO serializer, power flags and the single-outstanding mem port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      sh_in        <= '0;
      fast         <= 1'b0;
      nxt_addr     <= '0;
      sh_out       <= '0;
      buf_vld      <= 1'b0;
      buf_dat      <= '0;
      req_want     <= 1'b0;
      flash_io1_do <= 1'b0;
      flash_io1_oe <= 1'b0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      powered_down <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (start) bit_cnt <= '0;
      if (shift_en) begin
        sh_in   <= addr_full[22:0];
        bit_cnt <= bit_cnt + 8'd1;
      end
      if (cmd_done) begin
        bit_cnt <= '0;
        fast    <= (op_byte == OP_FREAD);
        if (op_byte == OP_RPD)                     powered_down <= 1'b0;
        else if (op_byte == OP_PD && !powered_down) powered_down <= 1'b1;
      end
      if (addr_done || dummy_done) bit_cnt <= '0;
      if (new_req) nxt_addr <= req_addr;
      if (data_fall) begin
        bit_cnt      <= bit_cnt + 8'd1;
        flash_io1_oe <= 1'b1;
        if (byte_edge) begin
          flash_io1_do <= byte_out[7];
          sh_out       <= {byte_out[6:0], 1'b0};
          buf_vld      <= 1'b0;
          if (!buf_vld) underrun <= 1'b1;
        end else begin
          flash_io1_do <= sh_out[7];
          sh_out       <= {sh_out[6:0], 1'b0};
        end
      end
      if (mem_valid && mem_ready) mem_valid <= 1'b0;
      if (buf_load) begin
        buf_vld <= 1'b1;
        buf_dat <= mem_rdata;
      end
      if (new_req) begin
        if (!mem_valid) begin
          mem_valid <= 1'b1;
          mem_addr  <= req_addr;
          req_want  <= 1'b0;
        end else begin
          req_want  <= 1'b1;
        end
      end else if (req_want && !mem_valid && !csb_s) begin
        mem_valid <= 1'b1;
        mem_addr  <= nxt_addr;
        req_want  <= 1'b0;
      end
      if (csb_rise) begin
        flash_io1_oe <= 1'b0;
        flash_io1_do <= 1'b0;
        buf_vld      <= 1'b0;
        req_want     <= 1'b0;
      end
    end
  end

endmodule
